// File: rtl/sar_cmp_pkg.sv
// -----------------------------------------------------------------------------
// sar_cmp_pkg
// Shared types and constants for the SAR comparator controller.
//   sar_state_e   : controller state encoding
//   SAR_*_DEF     : default parameter values for sar_cmp_ctrl
//   cnt_width()   : bit width of a down-counter able to hold a given value
// -----------------------------------------------------------------------------
package sar_cmp_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      SAMPLE = 3'd1,
      SETTLE = 3'd2,
      DECIDE = 3'd3,
      DONE   = 3'd4
   } sar_state_e;

   localparam int SAR_WIDTH_DEF   = 32'sd8;
   localparam int SAR_SAMPLE_DEF  = 32'sd2;
   localparam int SAR_SETTLE_DEF  = 32'sd2;
   localparam int SAR_TIMEOUT_DEF = 32'sd4;

   // Width needed to hold max_val; never below 2 so decrement constants stay legal.
   function automatic int cnt_width(input int max_val);
      int w;
      w = $clog2(max_val + 32'sd1);
      return (w < 32'sd2) ? 32'sd2 : w;
   endfunction

endpackage

// File: rtl/sar_phase_timer.sv
// -----------------------------------------------------------------------------
// sar_phase_timer
// Loadable down-counter shared by the SAMPLE, SETTLE and DECIDE-timeout phases.
// Loading value N makes expired assert on the (N+1)-th cycle after the load.
// Ports:
//   clk, rst  : clock, synchronous active-high reset (clears the count)
//   load      : load load_val on the next edge (has priority over counting)
//   load_val  : value to load
//   expired   : count has reached zero
// -----------------------------------------------------------------------------
module sar_phase_timer #(
   parameter int CW = 32'sd3
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          load,
   input  logic [CW-1:0] load_val,
   output logic          expired
);

   localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
   localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};

   logic [CW-1:0] count_r;

   // Reload on request, otherwise count down and park at zero.
   always_ff @(posedge clk) begin
      if (rst) begin
         count_r <= CNT_ZERO;
      end else if (load) begin
         count_r <= load_val;
      end else if (count_r != CNT_ZERO) begin
         count_r <= count_r - CNT_ONE;
      end else begin
         count_r <= count_r;
      end
   end

   assign expired = (count_r == CNT_ZERO);

endmodule

// File: rtl/sar_cmp_ctrl.sv
// -----------------------------------------------------------------------------
// sar_cmp_ctrl
// Successive-approximation controller for a gate-level comparator + ref DAC.
// Tracks the input (SAMPLE), then for each bit from MSB to LSB drives a trial
// code (SETTLE), reads the comparator (DECIDE) and keeps or clears the bit.
// A comparator that stays undriven (cmp_valid=0) for TIMEOUT_CYCLES extra
// clocks resolves the bit to 0 and raises the sticky undecided flag.
// Optional build macro: SAR_CMP_CTRL_CONT_MODE_EN -- when defined, DONE goes
// straight back to SAMPLE while start is held (free-running conversions).
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   start      : conversion request, only looked at in IDLE (and DONE when
//                continuous mode is built in)
//   cmp_out    : comparator decision, 1 = input above DAC
//   cmp_valid  : comparator output is being driven
//   sample     : high during the track phase
//   dac_code   : trial code to the reference DAC
//   busy       : high in every state but IDLE
//   done       : one-cycle pulse, result/undecided updated
//   result     : last completed conversion
//   undecided  : a bit of the last conversion timed out
// -----------------------------------------------------------------------------
module sar_cmp_ctrl
   import sar_cmp_pkg::*;
#(
   parameter int WIDTH          = SAR_WIDTH_DEF,
   parameter int SAMPLE_CYCLES  = SAR_SAMPLE_DEF,
   parameter int SETTLE_CYCLES  = SAR_SETTLE_DEF,
   parameter int TIMEOUT_CYCLES = SAR_TIMEOUT_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             cmp_out,
   input  logic             cmp_valid,
   output logic             sample,
   output logic [WIDTH-1:0] dac_code,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             undecided
);

   localparam int TMR_MAX_A = (SAMPLE_CYCLES > SETTLE_CYCLES) ? SAMPLE_CYCLES : SETTLE_CYCLES;
   localparam int TMR_MAX   = (TMR_MAX_A > TIMEOUT_CYCLES) ? TMR_MAX_A : TIMEOUT_CYCLES;
   localparam int CW        = cnt_width(TMR_MAX);
   localparam int BW        = cnt_width(WIDTH - 32'sd1);

   // Timer reload values: N-1 gives an N-cycle phase; the timeout wait is
   // loaded with TIMEOUT_CYCLES itself so it adds exactly that many clocks.
   localparam logic [CW-1:0]    SAMPLE_LD  = CW'(SAMPLE_CYCLES - 32'sd1);
   localparam logic [CW-1:0]    SETTLE_LD  = CW'(SETTLE_CYCLES - 32'sd1);
   localparam logic [CW-1:0]    TIMEOUT_LD = CW'(TIMEOUT_CYCLES);
   localparam logic [BW-1:0]    BIT_TOP    = BW'(WIDTH - 32'sd1);
   localparam logic [BW-1:0]    BIT_ZERO   = {BW{1'b0}};
   localparam logic [BW-1:0]    BIT_ONE    = {{(BW-1){1'b0}}, 1'b1};
   localparam logic [WIDTH-1:0] CODE_ZERO  = {WIDTH{1'b0}};
   localparam logic [WIDTH-1:0] CODE_ONE   = {{(WIDTH-1){1'b0}}, 1'b1};

   sar_state_e       state_r;
   logic [WIDTH-1:0] work_r;
   logic [BW-1:0]    bit_r;
   logic             flag_r;

   logic             tmr_load_s;
   logic [CW-1:0]    tmr_val_s;
   logic             tmr_expired_s;
   logic             decided_s;
   logic             bit_val_s;
   logic             timed_out_s;
   logic             last_bit_s;
   logic [WIDTH-1:0] bit_mask_s;
   logic [WIDTH-1:0] next_mask_s;
   logic [WIDTH-1:0] work_next_s;

   sar_phase_timer #(.CW(CW)) u_timer (
      .clk      (clk),
      .rst      (rst),
      .load     (tmr_load_s),
      .load_val (tmr_val_s),
      .expired  (tmr_expired_s)
   );

   // next_mask_s is only consumed when bit_r is non-zero, so the index never wraps.
   assign last_bit_s  = (bit_r == BIT_ZERO);
   assign bit_mask_s  = CODE_ONE << bit_r;
   assign next_mask_s = CODE_ONE << (bit_r - BIT_ONE);
   assign work_next_s = bit_val_s ? (work_r | bit_mask_s) : (work_r & ~bit_mask_s);

   // Bit decision: a driven comparator wins; an expired wait forces the bit to 0.
   always_comb begin
      decided_s   = 1'b0;
      bit_val_s   = 1'b0;
      timed_out_s = 1'b0;
      if (state_r == DECIDE) begin
         if (cmp_valid) begin
            decided_s = 1'b1;
            bit_val_s = cmp_out;
         end else if (tmr_expired_s) begin
            decided_s   = 1'b1;
            timed_out_s = 1'b1;
         end else begin
            decided_s = 1'b0;
         end
      end else begin
         decided_s = 1'b0;
      end
   end

   // Timer reload: arm the length of whichever phase is entered next.
   always_comb begin
      tmr_load_s = 1'b0;
      tmr_val_s  = SAMPLE_LD;
      case (state_r)
         IDLE: begin
            tmr_load_s = start;
            tmr_val_s  = SAMPLE_LD;
         end
         SAMPLE: begin
            tmr_load_s = tmr_expired_s;
            tmr_val_s  = SETTLE_LD;
         end
         SETTLE: begin
            tmr_load_s = tmr_expired_s;
            tmr_val_s  = TIMEOUT_LD;
         end
         DECIDE: begin
            tmr_load_s = decided_s & ~last_bit_s;
            tmr_val_s  = SETTLE_LD;
         end
         DONE: begin
`ifdef SAR_CMP_CTRL_CONT_MODE_EN
            tmr_load_s = start;
`else
            tmr_load_s = 1'b0;
`endif
            tmr_val_s  = SAMPLE_LD;
         end
         default: begin
            tmr_load_s = 1'b0;
            tmr_val_s  = SAMPLE_LD;
         end
      endcase
   end

   // Conversion FSM; every output is set on the transition into its state.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r   <= IDLE;
         work_r    <= CODE_ZERO;
         bit_r     <= BIT_ZERO;
         flag_r    <= 1'b0;
         sample    <= 1'b0;
         dac_code  <= CODE_ZERO;
         busy      <= 1'b0;
         done      <= 1'b0;
         result    <= CODE_ZERO;
         undecided <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               done     <= 1'b0;
               dac_code <= CODE_ZERO;
               if (start) begin
                  state_r <= SAMPLE;
                  sample  <= 1'b1;
                  busy    <= 1'b1;
                  work_r  <= CODE_ZERO;
                  bit_r   <= BIT_TOP;
                  flag_r  <= 1'b0;
               end
            end
            SAMPLE: begin
               if (tmr_expired_s) begin
                  state_r  <= SETTLE;
                  sample   <= 1'b0;
                  dac_code <= work_r | bit_mask_s;
               end
            end
            SETTLE: begin
               if (tmr_expired_s) begin
                  state_r <= DECIDE;
               end
            end
            DECIDE: begin
               if (decided_s) begin
                  work_r <= work_next_s;
                  flag_r <= flag_r | timed_out_s;
                  if (last_bit_s) begin
                     state_r   <= DONE;
                     done      <= 1'b1;
                     result    <= work_next_s;
                     undecided <= flag_r | timed_out_s;
                  end else begin
                     state_r  <= SETTLE;
                     bit_r    <= bit_r - BIT_ONE;
                     dac_code <= work_next_s | next_mask_s;
                  end
               end
            end
            DONE: begin
               done     <= 1'b0;
               dac_code <= CODE_ZERO;
`ifdef SAR_CMP_CTRL_CONT_MODE_EN
               if (start) begin
                  state_r <= SAMPLE;
                  sample  <= 1'b1;
                  work_r  <= CODE_ZERO;
                  bit_r   <= BIT_TOP;
                  flag_r  <= 1'b0;
               end else begin
                  state_r <= IDLE;
                  busy    <= 1'b0;
               end
`else
               state_r <= IDLE;
               busy    <= 1'b0;
`endif
            end
            default: begin
               state_r  <= IDLE;
               sample   <= 1'b0;
               dac_code <= CODE_ZERO;
               busy     <= 1'b0;
               done     <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sar_cmp_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sar_cmp_ctrl
// Self-checking bench for sar_cmp_ctrl. The comparator is modelled as an input
// sitting half an LSB above vin_code, so "input > DAC" means vin_code >= code.
// hang_mask lists bit positions whose comparator decision never arrives; the
// comparator is undriven whenever the DAC's lowest set bit (the bit on trial)
// is in that mask, and cmp_out then carries random junk.
// -----------------------------------------------------------------------------
module tb_sar_cmp_ctrl;

   localparam int W  = 8;
   localparam int S  = 2;
   localparam int T  = 2;
   localparam int TO = 4;
   localparam int LAT_BASE = 1 + S + W * (T + 1);
`ifdef SAR_CMP_CTRL_CONT_MODE_EN
   localparam int HOLD_PERIOD = LAT_BASE;      // DONE straight into SAMPLE
`else
   localparam int HOLD_PERIOD = LAT_BASE + 1;  // DONE, IDLE, then SAMPLE
`endif
   localparam int BUDGET = 200;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic         cmp_out;
   logic         cmp_valid;
   logic         sample;
   logic [W-1:0] dac_code;
   logic         busy;
   logic         done;
   logic [W-1:0] result;
   logic         undecided;

   logic [W-1:0] vin_code  = '0;
   logic [W-1:0] hang_mask = '0;
   logic [W-1:0] trial_bit;
   logic         junk = 1'b0;

   int n_tests = 0;
   int n_fail  = 0;
   logic [W-1:0] exp_trials[$];
   logic [W-1:0] obs_trials[$];

   sar_cmp_ctrl #(
      .WIDTH(W), .SAMPLE_CYCLES(S), .SETTLE_CYCLES(T), .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .cmp_out(cmp_out), .cmp_valid(cmp_valid),
      .sample(sample), .dac_code(dac_code), .busy(busy), .done(done),
      .result(result), .undecided(undecided)
   );

   always #5 clk = ~clk;

   // Comparator environment model.
   assign trial_bit = dac_code & (~dac_code + W'(1));
   assign cmp_valid = ~|(hang_mask & trial_bit);
   assign cmp_out   = cmp_valid ? (vin_code >= dac_code) : junk;

   // Fresh junk on the undriven comparator output every cycle.
   always @(negedge clk) junk <= 1'($urandom_range(0, 1));

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Reference: binary search over codes, hung bits forced to 0.
   task automatic model_sar(input int vin, input int mask, output int res, output int und,
                            output int lat);
      int acc;
      int trial;
      acc = 0;
      und = 0;
      lat = LAT_BASE;
      exp_trials.delete();
      for (int b = W - 1; b >= 0; b--) begin
         trial = acc + (1 << b);
         exp_trials.push_back(W'(trial));
         if (((mask >> b) & 1) != 0) begin
            und = 1;
            lat = lat + TO;
         end else if (vin >= trial) begin
            acc = trial;
         end
      end
      res = acc;
   endtask

   // Present start for exactly one edge; returns #1 after that edge.
   task automatic kick_start();
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   task automatic wait_done(input string tag, output int cycles);
      bit got;
      got = 1'b0;
      cycles = 0;
      while (!got && cycles < BUDGET) begin
         @(posedge clk);
         #1;
         cycles++;
         if (done) got = 1'b1;
      end
      check_eq(tag, 32'(got), 32'd1);
   endtask

   // One full conversion; optional stray start pulses at cycles 5 and 20.
   task automatic run_conv(input int vin, input int mask, input bit extra);
      int res, und, lat, c, n_sample, n_idle;
      logic [W-1:0] prev;
      logic [31:0] ov;
      bit got;
      model_sar(vin, mask, res, und, lat);
      vin_code  = W'(vin);
      hang_mask = W'(mask);
      obs_trials.delete();
      prev = '0;
      n_sample = 0;
      n_idle = 0;
      got = 1'b0;
      kick_start();
      c = 1;
      while (!got && c <= BUDGET) begin
         if (sample) n_sample++;
         if (!busy) n_idle++;
         if (dac_code != prev && dac_code != '0) obs_trials.push_back(dac_code);
         prev = dac_code;
         if (done) begin
            got = 1'b1;
         end else begin
            start = extra && (c == 5 || c == 20);
            @(posedge clk);
            #1;
            c++;
         end
      end
      start = 1'b0;
      check_eq("done_seen", 32'(got), 32'd1);
      check_eq("latency", 32'(c), 32'(lat));
      check_eq("result", 32'(result), 32'(res));
      check_eq("undecided", 32'(undecided), 32'(und));
      check_eq("sample_len", 32'(n_sample), 32'(S));
      check_eq("busy_gap", 32'(n_idle), 32'd0);
      check_eq("trial_cnt", 32'(obs_trials.size()), 32'(exp_trials.size()));
      foreach (exp_trials[i]) begin
         ov = 'x;
         if (i < obs_trials.size()) ov = 32'(obs_trials[i]);
         check_eq($sformatf("trial%0d", i), ov, 32'(exp_trials[i]));
      end
      @(posedge clk);
      #1;
      check_eq("done_pulse", 32'(done), 32'd0);
      check_eq("idle_busy", 32'(busy), 32'd0);
      check_eq("idle_dac", 32'(dac_code), 32'd0);
      repeat (4) @(posedge clk);
      #1;
      check_eq("no_queue", 32'(busy), 32'd0);
      check_eq("result_hold", 32'(result), 32'(res));
      check_eq("und_hold", 32'(undecided), 32'(und));
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int res, und, lat, cyc, n_done, vin, mask;
      rst = 1'b1;
      start = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_eq("rst_busy", 32'(busy), 32'd0);
      check_eq("rst_done", 32'(done), 32'd0);
      check_eq("rst_sample", 32'(sample), 32'd0);
      check_eq("rst_dac", 32'(dac_code), 32'd0);
      check_eq("rst_result", 32'(result), 32'd0);
      check_eq("rst_und", 32'(undecided), 32'd0);
      rst = 1'b0;
      repeat (2) @(posedge clk);

      // Directed patterns, boundaries and a hung bit-3 decision.
      run_conv(32'hA5, 0, 1'b0);
      run_conv(32'h00, 0, 1'b0);
      run_conv(32'hFF, 0, 1'b0);
      run_conv(32'hFF, 32'h08, 1'b0);
      run_conv(32'h5A, 0, 1'b1);

      // Randomized conversions, some with a hung bit and stray starts.
      for (int n = 0; n < 16; n++) begin
         vin  = int'($urandom_range(0, (1 << W) - 1));
         mask = ($urandom_range(0, 3) == 0) ? (1 << $urandom_range(0, W - 1)) : 0;
         run_conv(vin, mask, 1'($urandom_range(0, 1)));
      end

      // Reset during the bit-4 SETTLE aborts without a done pulse.
      model_sar(32'hFF, 0, res, und, lat);
      vin_code  = 8'hFF;
      hang_mask = '0;
      kick_start();
      repeat (11) @(posedge clk);
      #1;
      check_eq("mid_dac", 32'(dac_code), 32'(exp_trials[3]));
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      check_eq("abort_busy", 32'(busy), 32'd0);
      check_eq("abort_dac", 32'(dac_code), 32'd0);
      check_eq("abort_done", 32'(done), 32'd0);
      check_eq("abort_result", 32'(result), 32'd0);
      n_done = 0;
      repeat (40) begin
         @(posedge clk);
         #1;
         if (done) n_done++;
      end
      check_eq("abort_no_done", 32'(n_done), 32'd0);
      run_conv(32'h3E, 0, 1'b0);

      // start held high: back-to-back conversions, then drop start.
      model_sar(32'h3C, 0, res, und, lat);
      vin_code = 8'h3C;
      @(negedge clk);
      start = 1'b1;
      wait_done("hold_done1", cyc);
      check_eq("hold_lat", 32'(cyc), 32'(LAT_BASE));
      check_eq("hold_res1", 32'(result), 32'(res));
      model_sar(32'hC3, 0, res, und, lat);
      vin_code = 8'hC3;
      wait_done("hold_done2", cyc);
      check_eq("hold_period", 32'(cyc), 32'(HOLD_PERIOD));
      check_eq("hold_res2", 32'(result), 32'(res));
      start = 1'b0;
      @(posedge clk);
      #1;
      check_eq("drop_busy", 32'(busy), 32'd0);
      repeat (3) @(posedge clk);
      #1;
      check_eq("drop_idle", 32'(busy), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
